// File: rtl/p2s_pkg.sv
// Shared types and constants for the p2s_stream serial transmitter.
package p2s_pkg;

    // Transfer sequencing states of the transmitter.
    typedef enum logic [2:0] {
        IDLE,
        LOW,
        HIGH,
        LATCH,
        DONE
    } p2s_state_t;

    // Bit-order selectors for the DIR parameter.
    localparam bit P2S_LSB_FIRST = 1'b1;
    localparam bit P2S_MSB_FIRST = 1'b0;

    // Counter widths must never collapse to zero bits.
    function automatic int p2s_max1(input int v);
        return (v < 1) ? 1 : v;
    endfunction

endpackage

// File: rtl/p2s_shreg.sv
// Parallel-load shift register; shifts toward the serial output end, filling with 0.
module p2s_shreg
    import p2s_pkg::*;
#(
    parameter int DATA_BITS = 64,
    parameter bit DIR       = P2S_LSB_FIRST
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 shift,
    input  logic [DATA_BITS-1:0] d,
    output logic [DATA_BITS-1:0] q_out
);

    logic [DATA_BITS-1:0] word_q;
    logic [DATA_BITS-1:0] word_d;

    // Load has priority over shift; otherwise the word is held.
    always_comb begin
        word_d = word_q;
        if (load) begin
            word_d = d;
        end else if (shift) begin
            word_d = (DIR == P2S_LSB_FIRST) ? (word_q >> 1) : (word_q << 1);
        end
    end

    // Word register, cleared on reset so no stale data is ever presented.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_q <= '0;
        end else begin
            word_q <= word_d;
        end
    end

    assign q_out = word_q;

endmodule

// File: rtl/p2s_stream.sv
// Parallel-to-serial transmitter for 74LS164/74HC595-style shift chains.
// Every output is a register loaded from the next-state decode, so pin
// levels in a cycle always correspond to the state held in that cycle.
module p2s_stream
    import p2s_pkg::*;
#(
    parameter int DATA_BITS = 64,
    parameter bit DIR       = P2S_LSB_FIRST,
    parameter int CLK_DIV   = 1,
    parameter bit LATCH_EN  = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DATA_BITS-1:0] pdata,
    output logic                 ready,
    output logic                 done,
    output logic                 s_clk,
    output logic                 s_clrn,
    output logic                 sout,
    output logic                 s_latch
);

    localparam int PH_W = p2s_max1($clog2(CLK_DIV));
    localparam int BC_W = $clog2(DATA_BITS + 1);
    localparam logic [PH_W-1:0] PH_LAST  = PH_W'(CLK_DIV - 1);
    localparam logic [BC_W-1:0] BIT_LAST = BC_W'(DATA_BITS - 1);

    p2s_state_t state_q, state_d;
    logic [PH_W-1:0] ph_q, ph_d;
    logic [BC_W-1:0] bc_q, bc_d;

    logic ready_q, ready_d;
    logic done_q, done_d;
    logic s_clk_q, s_clk_d;
    logic s_clrn_q;
    logic sout_q, sout_d;
    logic s_latch_q, s_latch_d;

    logic                 load;
    logic                 shift;
    logic                 ph_last;
    logic [DATA_BITS-1:0] word;
    logic [DATA_BITS-1:0] word_nxt;

    // Bit presented on sout for a given register word.
    function automatic logic out_bit(input logic [DATA_BITS-1:0] w);
        return (DIR == P2S_LSB_FIRST) ? w[0] : w[DATA_BITS-1];
    endfunction

    // Word after one shift toward the output end.
    function automatic logic [DATA_BITS-1:0] shifted(input logic [DATA_BITS-1:0] w);
        return (DIR == P2S_LSB_FIRST) ? (w >> 1) : (w << 1);
    endfunction

    p2s_shreg #(
        .DATA_BITS(DATA_BITS),
        .DIR      (DIR)
    ) u_shreg (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .shift(shift),
        .d    (pdata),
        .q_out(word)
    );

    assign ph_last = (ph_q == PH_LAST);

    // Next-state, counter and output decode; outputs follow the next state.
    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        bc_d    = bc_q;
        load    = 1'b0;
        shift   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    ph_d    = '0;
                    bc_d    = '0;
                    state_d = LOW;
                end
            end
            LOW: begin
                if (ph_last) begin
                    ph_d    = '0;
                    state_d = HIGH;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            HIGH: begin
                if (ph_last) begin
                    ph_d  = '0;
                    shift = 1'b1;
                    bc_d  = bc_q + 1'b1;
                    if (bc_q == BIT_LAST) begin
                        state_d = LATCH_EN ? LATCH : DONE;
                    end else begin
                        state_d = LOW;
                    end
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            LATCH: begin
                if (ph_last) begin
                    ph_d    = '0;
                    state_d = DONE;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The word the shift register will hold next cycle drives the next sout.
        word_nxt = word;
        if (load) begin
            word_nxt = pdata;
        end else if (shift) begin
            word_nxt = shifted(word);
        end

        ready_d   = (state_d == IDLE);
        done_d    = (state_d == DONE);
        s_clk_d   = (state_d == HIGH);
        s_latch_d = (state_d == LATCH);
        sout_d    = ((state_d == LOW) || (state_d == HIGH)) ? out_bit(word_nxt) : 1'b0;
    end

    // State, counters and registered pins; reset forces every pin inactive and clears the chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ph_q      <= '0;
            bc_q      <= '0;
            ready_q   <= 1'b0;
            done_q    <= 1'b0;
            s_clk_q   <= 1'b0;
            s_clrn_q  <= 1'b0;
            sout_q    <= 1'b0;
            s_latch_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ph_q      <= ph_d;
            bc_q      <= bc_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            s_clk_q   <= s_clk_d;
            s_clrn_q  <= 1'b1;
            sout_q    <= sout_d;
            s_latch_q <= s_latch_d;
        end
    end

    assign ready   = ready_q;
    assign done    = done_q;
    assign s_clk   = s_clk_q;
    assign s_clrn  = s_clrn_q;
    assign sout    = sout_q;
    assign s_latch = s_latch_q;

endmodule

// File: tb/tb_p2s_stream.sv
// Directed bench for p2s_stream: three configurations share one clock; serial
// bits are checked against a scoreboard queue filled when each word is driven.
module tb_p2s_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start_a, start_b, start_c;
    logic [7:0] pd_a, pd_b;
    logic [3:0] pd_c;
    logic rdy_a, dn_a, sck_a, clr_a, so_a, lat_a;
    logic rdy_b, dn_b, sck_b, clr_b, so_b, lat_b;
    logic rdy_c, dn_c, sck_c, clr_c, so_c, lat_c;

    int n_run  = 0;
    int n_fail = 0;
    logic exp_q[$];

    // A: 8 bits, LSB first, CLK_DIV=1, latch
    p2s_stream #(.DATA_BITS(8), .DIR(1'b1), .CLK_DIV(1), .LATCH_EN(1'b1)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .pdata(pd_a), .ready(rdy_a), .done(dn_a),
        .s_clk(sck_a), .s_clrn(clr_a), .sout(so_a), .s_latch(lat_a));

    // B: 8 bits, MSB first, CLK_DIV=1, latch
    p2s_stream #(.DATA_BITS(8), .DIR(1'b0), .CLK_DIV(1), .LATCH_EN(1'b1)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .pdata(pd_b), .ready(rdy_b), .done(dn_b),
        .s_clk(sck_b), .s_clrn(clr_b), .sout(so_b), .s_latch(lat_b));

    // C: 4 bits, LSB first, CLK_DIV=3, no latch
    p2s_stream #(.DATA_BITS(4), .DIR(1'b1), .CLK_DIV(3), .LATCH_EN(1'b0)) u_c (
        .clk(clk), .rst(rst), .start(start_c), .pdata(pd_c), .ready(rdy_c), .done(dn_c),
        .s_clk(sck_c), .s_clrn(clr_c), .sout(so_c), .s_latch(lat_c));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input logic s, input logic [7:0] p);
        case (sel)
            0: begin start_a = s; pd_a = p; end
            1: begin start_b = s; pd_b = p; end
            default: begin start_c = s; pd_c = p[3:0]; end
        endcase
    endtask

    task automatic get(input int sel, output logic rdy, output logic dn, output logic sck,
                       output logic clr, output logic so, output logic lat);
        case (sel)
            0: begin rdy = rdy_a; dn = dn_a; sck = sck_a; clr = clr_a; so = so_a; lat = lat_a; end
            1: begin rdy = rdy_b; dn = dn_b; sck = sck_b; clr = clr_b; so = so_b; lat = lat_b; end
            default: begin rdy = rdy_c; dn = dn_c; sck = sck_c; clr = clr_c; so = so_c; lat = lat_c; end
        endcase
    endtask

    // Called in cycle 0 (#1 after an edge); returns in cycle T+1 of this transfer.
    task automatic run(input int sel, input logic [7:0] pd, input int nb, input int cd,
                       input int le, input bit dir, input bit spam);
        int T, rises, dones, lats, hi_run, bad_ready, bad_hold, idx;
        logic rdy, dn, sck, clr, so, lat, psck, pso, e;
        logic [7:0] sh;
        T = 2 * cd * nb + le * cd + 1;
        for (int k = 0; k < nb; k++) begin
            idx = dir ? k : (nb - 1 - k);
            sh  = pd >> idx;
            exp_q.push_back(sh[0]);
        end
        drive(sel, 1'b1, pd);
        get(sel, rdy, dn, sck, clr, so, lat);
        chk("ready_at_accept", rdy, 1);
        psck = 1'b0; pso = 1'b0;
        rises = 0; dones = 0; lats = 0; hi_run = 0; bad_ready = 0; bad_hold = 0;
        for (int cyc = 1; cyc <= T + 1; cyc++) begin
            @(posedge clk); #1;
            drive(sel, spam, ~pd);
            get(sel, rdy, dn, sck, clr, so, lat);
            if (sck && !psck) begin
                chk("rise_cycle", cyc, 1 + (2 * rises + 1) * cd);
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
                chk("sout_bit", so, e);
                rises++;
                hi_run = 1;
            end else if (sck && psck) begin
                hi_run++;
                if (so !== pso) bad_hold++;
            end
            if (!sck && psck) chk("high_run", hi_run, cd);
            if (lat) begin
                if (lats == 0) chk("latch_cycle", cyc, T - cd);
                chk("sout_in_latch", so, 0);
                lats++;
            end
            if (dn) begin
                chk("done_cycle", cyc, T);
                chk("sout_in_done", so, 0);
                dones++;
            end
            if (cyc <= T && rdy) bad_ready++;
            if (cyc == T + 1) begin
                chk("ready_back", rdy, 1);
                chk("clrn_high", clr, 1);
            end
            psck = sck;
            pso  = so;
        end
        chk("rise_count", rises, nb);
        chk("latch_len", lats, le * cd);
        chk("done_count", dones, 1);
        chk("ready_low_busy", bad_ready, 0);
        chk("sout_hold_high", bad_hold, 0);
        chk("sb_left", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        int rises, dones;
        logic rdy, dn, sck, clr, so, lat, psck;

        rst = 1'b1;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        pd_a = '0; pd_b = '0; pd_c = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            get(s, rdy, dn, sck, clr, so, lat);
            chk("rst_ready", rdy, 0);
            chk("rst_done", dn, 0);
            chk("rst_sclk", sck, 0);
            chk("rst_sout", so, 0);
            chk("rst_latch", lat, 0);
            chk("rst_clrn", clr, 0);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        for (int s = 0; s < 3; s++) begin
            get(s, rdy, dn, sck, clr, so, lat);
            chk("post_rst_ready", rdy, 1);
            chk("post_rst_clrn", clr, 1);
        end

        // LSB first, A5 -> 1,0,1,0,0,1,0,1; latch in 17, done in 18
        run(0, 8'hA5, 8, 1, 1, 1'b1, 1'b0);
        // MSB first
        run(1, 8'hA5, 8, 1, 1, 1'b0, 1'b0);
        run(1, 8'h01, 8, 1, 1, 1'b0, 1'b0);
        // CLK_DIV=3, 4 bits, no latch: done in 25
        run(2, 8'h0F, 4, 3, 0, 1'b1, 1'b0);
        // start held through a transfer, then accepted again at T+1
        run(0, 8'h3C, 8, 1, 1, 1'b1, 1'b1);
        run(0, 8'hC3, 8, 1, 1, 1'b1, 1'b0);

        // reset in cycle 5 of a transfer
        @(posedge clk); #1;
        drive(0, 1'b1, 8'hA5);
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            drive(0, 1'b0, 8'h5A);
        end
        chk("mid_sout_before_rst", so_a, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b1;
        chk("mid_rst_sclk", sck_a, 0);
        chk("mid_rst_sout", so_a, 0);
        chk("mid_rst_clrn", clr_a, 0);
        chk("mid_rst_ready", rdy_a, 0);
        chk("mid_rst_done", dn_a, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        start_a = 1'b0;
        @(posedge clk); #1;
        chk("after_rst_ready", rdy_a, 1);
        chk("after_rst_clrn", clr_a, 1);
        rises = 0; dones = 0; psck = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            if (sck_a && !psck) rises++;
            if (dn_a) dones++;
            psck = sck_a;
        end
        chk("after_rst_no_rise", rises, 0);
        chk("after_rst_no_done", dones, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
